// File: rtl/fetch_decode.sv
// Fetch and decode stage: drives the instruction RAM address and slices the
// returned word into opcode, register and immediate fields.
module fetch_decode #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 22,
  parameter int HALT_OP = 15,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               PC_Reset,
  input  logic [INSTR_W-1:0] RAMdata,
  input  logic               stall,
  output logic [ADDR_W-1:0]  address,
  output logic [3:0]         opcode,
  output logic [2:0]         srcA,
  output logic [2:0]         srcB,
  output logic [2:0]         dest,
  output logic [8:0]         imm,
  output logic               inst_valid,
  output logic [ADDR_W-1:0]  inst_addr,
  output logic               halted,
  output logic [COUNT_W-1:0] issue_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0]         HALT_CODE = 4'(HALT_OP);
  localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
  logic [COUNT_W-1:0]  issue_count_q, issue_count_d;
  logic                is_halt_s;
  logic                hold_s;

  assign opcode = RAMdata[21:18];
  assign srcA   = RAMdata[17:15];
  assign srcB   = RAMdata[14:12];
  assign dest   = RAMdata[11:9];
  assign imm    = RAMdata[8:0];

  assign is_halt_s = (opcode == HALT_CODE);
  assign hold_s    = (state_q == RUN) && (stall || is_halt_s);

  // Re-presenting inst_addr while held keeps the registered RAM output stable.
  assign address     = (hold_s || (state_q == HALTED)) ? inst_addr_q : pc_q;
  assign inst_valid  = (state_q == RUN);
  assign halted      = (state_q == HALTED);
  assign inst_addr   = inst_addr_q;
  assign issue_count = issue_count_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_addr_d   = inst_addr_q;
    issue_count_d = issue_count_q;
    case (state_q)
      IDLE: begin
        if (PC_Reset) begin
          pc_d = ADDR_ZERO;
        end else begin
          state_d     = RUN;
          inst_addr_d = ADDR_ZERO;
          pc_d        = ADDR_ONE;
        end
      end
      RUN: begin
        if (PC_Reset) begin
          state_d = IDLE;
          pc_d    = ADDR_ZERO;
        end else if (is_halt_s) begin
          state_d = HALTED;
        end else if (!stall) begin
          inst_addr_d = pc_q;
          pc_d        = pc_q + ADDR_ONE;
          if (issue_count_q != COUNT_MAX) begin
            issue_count_d = issue_count_q + COUNT_ONE;
          end else begin
            issue_count_d = issue_count_q;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      HALTED: begin
        if (PC_Reset) begin
          state_d = IDLE;
          pc_d    = ADDR_ZERO;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = ADDR_ZERO;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= ADDR_ZERO;
      inst_addr_q   <= ADDR_ZERO;
      issue_count_q <= {COUNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_addr_q   <= inst_addr_d;
      issue_count_q <= issue_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: a registered RAM model feeds the DUT; issued
// instructions are checked by a scoreboard, cycle behaviour by directed checks.
module tb_fetch_decode;

  logic        clock;
  logic        reset_n;
  logic        PC_Reset;
  logic [21:0] RAMdata;
  logic        stall;
  logic [9:0]  address;
  logic [3:0]  opcode;
  logic [2:0]  srcA;
  logic [2:0]  srcB;
  logic [2:0]  dest;
  logic [8:0]  imm;
  logic        inst_valid;
  logic [9:0]  inst_addr;
  logic        halted;
  logic [15:0] issue_count;

  logic [21:0] mem [0:1023];
  logic [41:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_decode dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .PC_Reset   (PC_Reset),
    .RAMdata    (RAMdata),
    .stall      (stall),
    .address    (address),
    .opcode     (opcode),
    .srcA       (srcA),
    .srcB       (srcB),
    .dest       (dest),
    .imm        (imm),
    .inst_valid (inst_valid),
    .inst_addr  (inst_addr),
    .halted     (halted),
    .issue_count(issue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction RAM: one-edge registered read.
  always @(posedge clock) RAMdata <= mem[address];

  function automatic logic [21:0] word_of(input int i);
    return {4'(i % 15), 18'((i * 37 + 11) % 262144)};
  endfunction

  // Expected entry: {inst_addr, word, address presented while it is live}.
  task automatic push_exp(input int a);
    logic [21:0] w;
    logic [9:0]  ea;
    w  = mem[a];
    ea = (w[21:18] == 4'd15) ? 10'(a) : 10'(a + 1);
    exp_q.push_back({10'(a), w, ea});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Monitor: an instruction is consumed on each cycle it is valid and not stalled.
  always @(negedge clock) begin
    logic [41:0] e;
    if (reset_n && inst_valid && !stall) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got inst_addr %0d expected no instruction", inst_addr);
      end else begin
        e = exp_q.pop_front();
        if ({inst_addr, opcode, srcA, srcB, dest, imm, address} !== e) begin
          n_fail++;
          $display("FAIL sb_issue: got %h expected %h",
                   {inst_addr, opcode, srcA, srcB, dest, imm, address}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    PC_Reset = 1'b1;
    stall    = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = word_of(i);
    mem[0] = 22'b0011_001_010_011_000000101;
    mem[5] = {4'd15, 18'h01234};

    repeat (3) step();
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(issue_count), 32'd0);

    reset_n = 1'b1;
    step();
    chk("idle_address", 32'(address), 32'd0);
    chk("idle_valid", 32'(inst_valid), 32'd0);
    PC_Reset = 1'b0;
    for (int a = 0; a < 6; a++) push_exp(a);
    step();
    chk("start_valid", 32'(inst_valid), 32'd1);
    chk("start_inst_addr", 32'(inst_addr), 32'd0);
    chk("start_address", 32'(address), 32'd1);
    chk("dec_opcode", 32'(opcode), 32'd3);
    chk("dec_srcA", 32'(srcA), 32'd1);
    chk("dec_srcB", 32'(srcB), 32'd2);
    chk("dec_dest", 32'(dest), 32'd3);
    chk("dec_imm", 32'(imm), 32'd5);

    step();
    chk("seq_address_2", 32'(address), 32'd2);
    step();
    chk("seq_address_3", 32'(address), 32'd3);
    chk("seq_inst_addr_2", 32'(inst_addr), 32'd2);

    stall = 1'b1;
    #1;
    chk("stall_address_now", 32'(address), 32'd2);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_address", 32'(address), 32'd2);
      chk("stall_inst_addr", 32'(inst_addr), 32'd2);
      chk("stall_count", 32'(issue_count), 32'd2);
    end
    stall = 1'b0;
    #1;
    chk("release_address", 32'(address), 32'd3);

    step();
    chk("seq_address_4", 32'(address), 32'd4);
    step();
    chk("seq_address_5", 32'(address), 32'd5);
    chk("seq_count_4", 32'(issue_count), 32'd4);

    step();
    chk("halt_inst_addr", 32'(inst_addr), 32'd5);
    chk("halt_address_same_cycle", 32'(address), 32'd5);
    chk("halt_valid_same_cycle", 32'(inst_valid), 32'd1);
    step();
    chk("halted_flag", 32'(halted), 32'd1);
    chk("halted_valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("halted_address", 32'(address), 32'd5);
    end
    chk("halted_count", 32'(issue_count), 32'd5);

    reset_n = 1'b0;
    #1;
    chk("midrst1_address", 32'(address), 32'd0);
    chk("midrst1_halted", 32'(halted), 32'd0);
    chk("midrst1_count", 32'(issue_count), 32'd0);
    chk("midrst1_inst_addr", 32'(inst_addr), 32'd0);

    for (int i = 0; i < 1024; i++) mem[i] = word_of(i);
    PC_Reset = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    PC_Reset = 1'b0;
    for (int a = 0; a < 1024; a++) push_exp(a);
    for (int a = 0; a < 8; a++) push_exp(a);
    step();
    chk("wrap_start_inst_addr", 32'(inst_addr), 32'd0);
    repeat (1023) step();
    chk("wrap_top_inst_addr", 32'(inst_addr), 32'd1023);
    chk("wrap_top_address", 32'(address), 32'd0);
    chk("wrap_top_count", 32'(issue_count), 32'd1023);
    step();
    chk("wrap_inst_addr", 32'(inst_addr), 32'd0);
    chk("wrap_address", 32'(address), 32'd1);
    chk("wrap_count", 32'(issue_count), 32'd1024);

    repeat (7) step();
    chk("restart_inst_addr", 32'(inst_addr), 32'd7);
    PC_Reset = 1'b1;
    step();
    chk("restart_address", 32'(address), 32'd0);
    chk("restart_valid", 32'(inst_valid), 32'd0);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_count_kept", 32'(issue_count), 32'd1031);

    PC_Reset = 1'b0;
    push_exp(0);
    push_exp(1);
    step();
    chk("rerun_valid", 32'(inst_valid), 32'd1);
    chk("rerun_inst_addr", 32'(inst_addr), 32'd0);
    chk("rerun_count", 32'(issue_count), 32'd1031);
    step();
    step();
    chk("rerun_count_2", 32'(issue_count), 32'd1033);

    reset_n = 1'b0;
    #1;
    chk("midrst2_address", 32'(address), 32'd0);
    chk("midrst2_valid", 32'(inst_valid), 32'd0);
    chk("midrst2_halted", 32'(halted), 32'd0);
    chk("midrst2_count", 32'(issue_count), 32'd0);
    chk("midrst2_inst_addr", 32'(inst_addr), 32'd0);

    step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
